delay_timer: RTL and testbench
==============================

// Module: delay_timer
// PURPOSE
//  Parametrised retriggerable delay/interval timer. Counts a programmable number of
//  prescaled ticks after a start request, then pulses time_out for one clk cycle.
//  Supports one-shot and periodic modes, cancel and optional retrigger. Used for
//  FSM timeouts, debounce windows and periodic strobes across the design.
// PARAMETERS
//  WIDTH     14  width of delay value n and of count
//  PRESCALE  1   clk cycles per tick (>=1; 1 = tick every clk)
//  RETRIG    0   1: trigger edge while busy restarts timer; 0: ignored while busy
// PORTS
//  clk       in   1      system clock, all state on posedge
//  rst_n     in   1      asynchronous active-low reset
//  n         in   WIDTH  delay value; expiry after (n+1) ticks
//  trigger   in   1      start request, rising-edge detected internally
//  periodic  in   1      0 one-shot, 1 auto-reload; latched at start
//  cancel    in   1      abort; level, sampled each clk
//  time_out  out  1      one-cycle expiry pulse (registered)
//  busy      out  1      high while counting
//  count     out  WIDTH  remaining ticks before expiry
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; time_out=0, busy=0, count=0, prescaler=0,
//    latched n/mode=0; trig_q=1, so trigger held high across reset release does not start.
//  - Start edge: trigger=1 and trig_q=0 at a posedge. trig_q <= trigger every clk.
//  - States: IDLE, RUN.
//    IDLE: start edge and !cancel -> RUN; count<=n, n_lat<=n, mode_lat<=periodic,
//      prescaler<=0.
//    RUN: tick = (prescaler==PRESCALE-1); prescaler wraps to 0 on tick, else +1.
//      On tick with count!=0: count<=count-1.
//      On tick with count==0: time_out<=1 for the next cycle only;
//        mode_lat=1 -> count<=n_lat and stay in RUN (no gap cycle);
//        mode_lat=0 -> IDLE, busy<=0.
//  - Latency: time_out is high in the cycle after edge S+(n+1)*PRESCALE (S = start edge).
//    n=0 -> first pulse after PRESCALE edges. Periodic period = (n+1)*PRESCALE clk, exact.
//  - n is read only at start. Changes to n or periodic during RUN have no effect.
//  - busy=1 exactly while state==RUN. It is registered and rises on the edge after start.
//  - cancel: highest priority.
//    - In RUN: -> IDLE, count<=0, prescaler<=0, no time_out.
//    - Same edge as expiry: cancel wins, no pulse.
//    - In IDLE: blocks a start edge on the same clk.
//  - Retrigger in RUN (RETRIG=1): reload count<=n, n_lat, mode_lat, clear prescaler.
//    - Coincident with an expiry tick: time_out still pulses and the reload takes effect.
//    - RETRIG=0: start edges in RUN are ignored.
//  - count is WIDTH-bit unsigned and never wraps below 0. n=all-ones is legal: 2^WIDTH ticks.
//  - Async reset mid-run: outputs clear immediately and no pulse occurs after release.
// TESTING
//  1. P=1, n=5, one-shot, trigger pulse at edge 0 -> time_out=1 only after edge 6, busy low
//     after edge 6.
//  2. n=0, P=1 -> time_out after edge 1. n=0, P=4 -> time_out after edge 4.
//  3. periodic=1, n=3 -> pulses every 4 clk, starting with the cycle after edge 4. cancel at
//     edge 10 -> no further pulses, busy=0, count=0.
//  4. RETRIG=1, n=5, second edge at count=2 -> expiry 6 ticks after the second edge.
//     RETRIG=0, same stimulus -> original expiry time, second edge ignored.
//  5. PRESCALE=4, n=2 -> time_out 12 clk after start. cancel on the expiry edge -> no pulse.
//  6. rst_n low mid-count -> outputs 0 asynchronously. trigger held 1 through release -> no
//     start until trigger falls and rises again.

Source files
------------

// File: rtl/delay_timer_if.sv
// Interface bundling the delay timer's control inputs and status outputs.
// The master side (controller) drives the delay value, trigger, mode and
// cancel; the slave side (the timer) drives the expiry pulse, busy and the
// remaining tick count.
interface delay_timer_if #(
    parameter int WIDTH = 14
);
    logic [WIDTH-1:0] n;
    logic             trigger;
    logic             periodic;
    logic             cancel;
    logic             time_out;
    logic             busy;
    logic [WIDTH-1:0] count;

    modport master (
        output n,
        output trigger,
        output periodic,
        output cancel,
        input  time_out,
        input  busy,
        input  count
    );

    modport slave (
        input  n,
        input  trigger,
        input  periodic,
        input  cancel,
        output time_out,
        output busy,
        output count
    );
endinterface

// File: rtl/delay_timer.sv
// Retriggerable delay / interval timer.
// A rising edge on trigger loads n and starts counting prescaled ticks; after
// (n+1) ticks time_out pulses for one clk. Periodic mode reloads without a gap
// cycle. cancel has priority over everything, including a coincident expiry.
module delay_timer #(
    parameter int WIDTH    = 14,
    parameter int PRESCALE = 1,
    parameter int RETRIG   = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    delay_timer_if.slave bus
);
    // Prescaler needs at least one bit even when every clk is a tick.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_reg,     state_next;
    logic [WIDTH-1:0] count_reg,     count_next;
    logic [WIDTH-1:0] n_lat_reg,     n_lat_next;
    logic             mode_lat_reg,  mode_lat_next;
    logic [PW-1:0]    prescaler_reg, prescaler_next;
    logic             trig_q_reg;
    logic             time_out_reg,  time_out_next;

    logic start_edge;
    logic tick;

    assign start_edge = bus.trigger & ~trig_q_reg;
    assign tick       = (prescaler_reg == PS_LAST);

    // State and datapath registers; trig_q resets high so a trigger held
    // across reset release is not mistaken for a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            n_lat_reg     <= '0;
            mode_lat_reg  <= 1'b0;
            prescaler_reg <= '0;
            trig_q_reg    <= 1'b1;
            time_out_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            n_lat_reg     <= n_lat_next;
            mode_lat_reg  <= mode_lat_next;
            prescaler_reg <= prescaler_next;
            trig_q_reg    <= bus.trigger;
            time_out_reg  <= time_out_next;
        end
    end

    // Next-state logic: start/cancel in IDLE, tick counting, expiry, reload
    // and optional retrigger in RUN.
    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        n_lat_next     = n_lat_reg;
        mode_lat_next  = mode_lat_reg;
        prescaler_next = prescaler_reg;
        time_out_next  = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (start_edge && !bus.cancel) begin
                    state_next     = RUN;
                    count_next     = bus.n;
                    n_lat_next     = bus.n;
                    mode_lat_next  = bus.periodic;
                    prescaler_next = '0;
                end
            end

            RUN: begin
                if (bus.cancel) begin
                    // Abort silently, even on what would have been the expiry tick.
                    state_next     = IDLE;
                    count_next     = '0;
                    prescaler_next = '0;
                end else begin
                    prescaler_next = tick ? '0 : prescaler_reg + PW'(1);
                    if (tick) begin
                        if (count_reg != '0) begin
                            count_next = count_reg - WIDTH'(1);
                        end else begin
                            time_out_next = 1'b1;
                            if (mode_lat_reg) begin
                                count_next = n_lat_reg;
                            end else begin
                                state_next = IDLE;
                            end
                        end
                    end
                    // A retrigger reloads on top of whatever the tick did, so a
                    // coincident expiry still pulses but the timer keeps running.
                    if (RETRIG != 0 && start_edge) begin
                        state_next     = RUN;
                        count_next     = bus.n;
                        n_lat_next     = bus.n;
                        mode_lat_next  = bus.periodic;
                        prescaler_next = '0;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.time_out = time_out_reg;
    assign bus.busy     = (state_reg == RUN);
    assign bus.count    = count_reg;

endmodule

// File: tb/tb_delay_timer.sv
// Directed bench for delay_timer: four instances cover PRESCALE=1/4,
// RETRIG=0/1 and a narrow WIDTH for the all-ones delay value.
module tb_delay_timer;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    delay_timer_if #(.WIDTH(14)) ifa ();
    delay_timer_if #(.WIDTH(14)) ifb ();
    delay_timer_if #(.WIDTH(14)) ifc ();
    delay_timer_if #(.WIDTH(3))  ifd ();

    delay_timer #(.WIDTH(14), .PRESCALE(1), .RETRIG(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    delay_timer #(.WIDTH(14), .PRESCALE(4), .RETRIG(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    delay_timer #(.WIDTH(14), .PRESCALE(1), .RETRIG(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));
    delay_timer #(.WIDTH(3),  .PRESCALE(1), .RETRIG(0)) dut_d (.clk(clk), .rst_n(rst_n), .bus(ifd));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        ifa.n = '0; ifa.trigger = 1'b0; ifa.periodic = 1'b0; ifa.cancel = 1'b0;
        ifb.n = '0; ifb.trigger = 1'b0; ifb.periodic = 1'b0; ifb.cancel = 1'b0;
        ifc.n = '0; ifc.trigger = 1'b0; ifc.periodic = 1'b0; ifc.cancel = 1'b0;
        ifd.n = '0; ifd.trigger = 1'b0; ifd.periodic = 1'b0; ifd.cancel = 1'b0;

        // Reset state
        step();
        chk("rst_a_busy", ifa.busy, 0);
        chk("rst_a_to", ifa.time_out, 0);
        chk("rst_a_count", ifa.count, 0);
        chk("rst_b_busy", ifb.busy, 0);
        #3 rst_n = 1'b1;
        step();
        step();
        $display("reset released, idle checks done");

        // 1: P=1, n=5 one-shot; pulse after edge 6 only
        ifa.n = 5; ifa.periodic = 1'b0; ifa.trigger = 1'b1;
        step();
        ifa.trigger = 1'b0;
        chk("t1_busy_start", ifa.busy, 1);
        chk("t1_count_start", ifa.count, 5);
        for (int e = 1; e <= 7; e++) begin
            step();
            chk("t1_to", ifa.time_out, (e == 6) ? 1 : 0);
            if (e == 5) chk("t1_busy_e5", ifa.busy, 1);
            if (e == 6) chk("t1_busy_e6", ifa.busy, 0);
        end
        $display("t1 one-shot n=5 done");

        // 2a: n=0, P=1 -> pulse after edge 1
        ifa.n = 0; ifa.trigger = 1'b1;
        step();
        ifa.trigger = 1'b0;
        chk("t2a_busy", ifa.busy, 1);
        chk("t2a_to_e0", ifa.time_out, 0);
        step();
        chk("t2a_to_e1", ifa.time_out, 1);
        chk("t2a_busy_e1", ifa.busy, 0);
        step();
        chk("t2a_to_e2", ifa.time_out, 0);
        $display("t2a n=0 P=1 done");

        // 2b: n=0, P=4 -> pulse after edge 4
        ifb.n = 0; ifb.trigger = 1'b1;
        step();
        ifb.trigger = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            step();
            chk("t2b_to", ifb.time_out, (e == 4) ? 1 : 0);
        end
        $display("t2b n=0 P=4 done");

        // 3: periodic n=3, pulses after edges 4, 8; cancel at edge 10.
        // n/periodic changed mid-run must have no effect.
        ifa.n = 3; ifa.periodic = 1'b1; ifa.trigger = 1'b1;
        step();
        ifa.trigger = 1'b0;
        ifa.n = 1; ifa.periodic = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            if (e == 10) ifa.cancel = 1'b1;
            step();
            ifa.cancel = 1'b0;
            chk("t3_to", ifa.time_out, (e == 4 || e == 8) ? 1 : 0);
            if (e == 10) begin
                chk("t3_busy_cancel", ifa.busy, 0);
                chk("t3_count_cancel", ifa.count, 0);
            end
        end
        chk("t3_busy_end", ifa.busy, 0);
        $display("t3 periodic + cancel done");

        // 3b: cancel in IDLE blocks a coincident start edge
        ifa.n = 3; ifa.trigger = 1'b1; ifa.cancel = 1'b1;
        step();
        ifa.cancel = 1'b0;
        chk("t3b_blocked", ifa.busy, 0);
        step();
        chk("t3b_no_late_start", ifa.busy, 0);
        ifa.trigger = 1'b0;
        step();
        $display("t3b cancel blocks start done");

        // 4: second edge at count=2 (edge 4). RETRIG=0 expires at edge 6,
        // RETRIG=1 reloads and expires at edge 10.
        ifa.n = 5; ifa.periodic = 1'b0; ifa.trigger = 1'b1;
        ifc.n = 5; ifc.periodic = 1'b0; ifc.trigger = 1'b1;
        step();
        ifa.trigger = 1'b0; ifc.trigger = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            if (e == 4) begin
                ifa.trigger = 1'b1; ifc.trigger = 1'b1;
            end
            step();
            if (e == 4) begin
                ifa.trigger = 1'b0; ifc.trigger = 1'b0;
                chk("t4_a_count_e4", ifa.count, 1);
                chk("t4_c_count_e4", ifc.count, 5);
            end
            chk("t4_a_to", ifa.time_out, (e == 6) ? 1 : 0);
            chk("t4_c_to", ifc.time_out, (e == 10) ? 1 : 0);
        end
        $display("t4 retrigger vs ignore done");

        // 4b: retrigger coincident with expiry tick: pulse and reload both happen
        ifc.n = 2; ifc.trigger = 1'b1;
        step();
        ifc.trigger = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            if (e == 3) ifc.trigger = 1'b1;
            step();
            if (e == 3) begin
                ifc.trigger = 1'b0;
                chk("t4b_count_reload", ifc.count, 2);
                chk("t4b_busy_reload", ifc.busy, 1);
            end
            chk("t4b_to", ifc.time_out, (e == 3 || e == 6) ? 1 : 0);
        end
        chk("t4b_busy_end", ifc.busy, 0);
        $display("t4b retrigger on expiry done");

        // 5: P=4, n=2 -> pulse after edge 12
        ifb.n = 2; ifb.periodic = 1'b0; ifb.trigger = 1'b1;
        step();
        ifb.trigger = 1'b0;
        for (int e = 1; e <= 13; e++) begin
            step();
            chk("t5_to", ifb.time_out, (e == 12) ? 1 : 0);
            if (e == 4) chk("t5_count_e4", ifb.count, 1);
        end
        $display("t5 prescaled expiry done");

        // 5b: cancel on the expiry edge suppresses the pulse
        ifb.trigger = 1'b1;
        step();
        ifb.trigger = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            if (e == 12) ifb.cancel = 1'b1;
            step();
            ifb.cancel = 1'b0;
            chk("t5b_to", ifb.time_out, 0);
            if (e == 12) chk("t5b_busy_cancel", ifb.busy, 0);
        end
        chk("t5b_count", ifb.count, 0);
        $display("t5b cancel on expiry done");

        // n = all-ones on a 3-bit timer -> 8 ticks
        ifd.n = 3'd7; ifd.trigger = 1'b1;
        step();
        ifd.trigger = 1'b0;
        chk("td_count_start", ifd.count, 7);
        for (int e = 1; e <= 9; e++) begin
            step();
            chk("td_to", ifd.time_out, (e == 8) ? 1 : 0);
        end
        $display("td all-ones delay done");

        // 6: async reset mid-count, trigger held high through release
        ifa.n = 10; ifa.periodic = 1'b0; ifa.trigger = 1'b1;
        step();
        chk("t6_busy_pre", ifa.busy, 1);
        step();
        step();
        #3 rst_n = 1'b0;
        #1;
        chk("t6_busy_async", ifa.busy, 0);
        chk("t6_count_async", ifa.count, 0);
        chk("t6_to_async", ifa.time_out, 0);
        step();
        #3 rst_n = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            step();
            chk("t6_idle_busy", ifa.busy, 0);
            chk("t6_idle_to", ifa.time_out, 0);
        end
        ifa.trigger = 1'b0;
        step();
        ifa.trigger = 1'b1;
        step();
        chk("t6_restart_busy", ifa.busy, 1);
        chk("t6_restart_count", ifa.count, 10);
        ifa.trigger = 1'b0; ifa.cancel = 1'b1;
        step();
        ifa.cancel = 1'b0;
        chk("t6_cancel_busy", ifa.busy, 0);
        $display("t6 async reset done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
